// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game pipeline.
package dino_pkg;

  // Vertical motion phase of the dino.
  typedef enum logic [1:0] {
    StGround  = 2'd0,
    StAscend  = 2'd1,
    StDescend = 2'd2
  } jump_state_e;

  // Position and velocity are carried in quarter-pixels.
  localparam int unsigned FRAC_BITS = 2;
  // Highest position that still maps to a 6-bit pixel offset (63 px).
  localparam int unsigned POS_MAX = 252;

  // OLED panel geometry.
  localparam int unsigned OLED_WIDTH  = 128;
  localparam int unsigned OLED_HEIGHT = 64;
  localparam int unsigned GROUND_ROW  = 56;

  // Clamp a 9-bit signed integration sum to the 8-bit position range.
  // The caller handles sums at or below zero (landing) separately.
  function automatic logic [7:0] sat_pos(input logic signed [8:0] sum);
    logic signed [8:0] pos_max_s;
    pos_max_s = 9'(POS_MAX);
    if (sum > pos_max_s) begin
      sat_pos = 8'(POS_MAX);
    end else begin
      sat_pos = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/dino_jump_physics_if.sv
// Button/frame inputs and dino height/status outputs of the jump physics stage.
interface dino_jump_physics_if;
  import dino_pkg::*;

  logic       btn_raw;
  logic       frame_tick;
  logic       game_over;
  logic       restart;
  logic       btn_level;
  logic [5:0] jump_offset;
  logic       airborne;
  logic       descending;
  logic       land_pulse;

  // Driver side: game control and button pin.
  modport master (
    output btn_raw,
    output frame_tick,
    output game_over,
    output restart,
    input  btn_level,
    input  jump_offset,
    input  airborne,
    input  descending,
    input  land_pulse
  );

  // Physics block side.
  modport slave (
    input  btn_raw,
    input  frame_tick,
    input  game_over,
    input  restart,
    output btn_level,
    output jump_offset,
    output airborne,
    output descending,
    output land_pulse
  );

endinterface

// File: rtl/dino_jump_physics_btn_debounce.sv
// Button synchroniser, polarity normalisation and debouncer with rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_rise_o
);

  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser resets to the released pin level so reset exit is quiet.
  localparam logic IdleRaw = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]      sync_q;
  logic            btn_norm;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  assign btn_norm = BTN_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{IdleRaw}};
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
    end
  end

  // Count cycles of disagreement; toggle the level once it has persisted long enough.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (btn_norm != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign btn_level_o = level_q;
  // High for exactly the first cycle in which btn_level_o reads pressed.
  assign btn_rise_o  = rise_q;

endmodule

// File: rtl/dino_jump_physics.sv
// Jump physics: debounced button request plus per-frame fixed-point gravity integration.
module dino_jump_physics
  import dino_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned JUMP_V0         = 24,
  parameter int unsigned GRAVITY         = 2
) (
  input logic               clk,
  input logic               rst_n,
  dino_jump_physics_if.slave bus
);

  localparam logic signed [7:0] V0 = 8'(JUMP_V0);
  localparam logic signed [7:0] G  = 8'(GRAVITY);

  jump_state_e       state_q, state_d;
  logic [7:0]        pos_q, pos_d;
  logic signed [7:0] vel_q, vel_d;
  logic              pending_q, pending_d;
  logic              land_q, land_d;

  logic              btn_level;
  logic              btn_rise;
  logic              jump_req;
  logic signed [8:0] sum;
  logic signed [7:0] vel_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw_i   (bus.btn_raw),
    .btn_level_o (btn_level),
    .btn_rise_o  (btn_rise)
  );

  // A press edge coinciding with a tick still counts for that tick.
  assign jump_req = pending_q | btn_rise;
  assign sum      = $signed({1'b0, pos_q}) + $signed({vel_q[7], vel_q});
  assign vel_next = vel_q - G;

  // Next-state: restart beats game_over beats frame_tick.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    pending_d = pending_q;
    land_d    = 1'b0;

    if (bus.restart) begin
      state_d   = StGround;
      pos_d     = '0;
      vel_d     = '0;
      pending_d = 1'b0;
    end else if (bus.game_over) begin
      pending_d = 1'b0;
    end else if (bus.frame_tick) begin
      pending_d = 1'b0;
      unique case (state_q)
        StGround: begin
          if (jump_req) begin
            state_d = StAscend;
            pos_d   = V0;
            vel_d   = V0 - G;
          end
        end
        StAscend, StDescend: begin
          // Requests while airborne are dropped, not buffered.
          if (sum <= 9'sd0) begin
            state_d = StGround;
            pos_d   = '0;
            vel_d   = '0;
            land_d  = 1'b1;
          end else begin
            pos_d   = sat_pos(sum);
            vel_d   = vel_next;
            state_d = (vel_next > 8'sd0) ? StAscend : StDescend;
          end
        end
        default: begin
          state_d = StGround;
          pos_d   = '0;
          vel_d   = '0;
        end
      endcase
    end else begin
      pending_d = pending_q | btn_rise;
    end
  end

  // Physics state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StGround;
      pos_q     <= '0;
      vel_q     <= '0;
      pending_q <= 1'b0;
      land_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
      land_q    <= land_d;
    end
  end

  assign bus.btn_level   = btn_level;
  assign bus.jump_offset = pos_q[7:FRAC_BITS];
  assign bus.airborne    = (state_q != StGround);
  assign bus.descending  = (state_q == StDescend);
  assign bus.land_pulse  = land_q;

endmodule
